// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - round-robin issue arbiter sharing one half-precision FPU between two requesters
// Optional build macro FPU_ARB_TIMEOUT_EN: abandon an operation after TIMEOUT_CYC cycles in WAIT.
module fpu_issue_arbiter #(
  parameter int OP_W        = 24,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_l,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_fs1,
  input  logic [DATA_W-1:0] req0_fs2,
  input  logic [DATA_W-1:0] req0_fs3,
  input  logic [2:0]        req0_rm,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_fs1,
  input  logic [DATA_W-1:0] req1_fs2,
  input  logic [DATA_W-1:0] req1_fs3,
  input  logic [2:0]        req1_rm,

  output logic              fpu_active,
  output logic [OP_W-1:0]   fpu_op,
  output logic [DATA_W-1:0] fpu_fs1,
  output logic [DATA_W-1:0] fpu_fs2,
  output logic [DATA_W-1:0] fpu_fs3,
  output logic [2:0]        fpu_rounding,
  input  logic              fpu_complete,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic [4:0]        fpu_sflag,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_flags,
  output logic              rsp_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   prio;      // port that wins when both request together
  logic   id_q;      // owner of the operation in flight
  logic   grant0, grant1;
  logic   accept;
  logic   win_id;
  logic   cpl_take;
  logic   to_fire;

  assign grant0     = req0_valid & (~req1_valid | ~prio);
  assign grant1     = req1_valid & (~req0_valid |  prio);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign win_id     = req1_ready;
  assign busy       = (state != IDLE);

  // Completions only count while an operation is actually outstanding.
  assign cpl_take   = fpu_complete & ((state == ISSUE) | (state == WAIT));

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;

  assign wait_cnt_inc = wait_cnt + CNT_W'(1);
  assign to_fire      = (state == WAIT) & ~fpu_complete & (wait_cnt_inc == CNT_W'(TIMEOUT_CYC));

  // Held at zero outside WAIT, so every WAIT entry starts counting from zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rsp_timeout <= 1'b0;
    end else if (cpl_take) begin
      rsp_timeout <= 1'b0;
    end else if (to_fire) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYC;

  assign to_fire     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = fpu_complete ? RESP : WAIT;
      WAIT:    if (fpu_complete || to_fire) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue side: operand capture, strobe and round-robin pointer.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      prio         <= 1'b0;
      id_q         <= 1'b0;
      fpu_active   <= 1'b0;
      fpu_op       <= '0;
      fpu_fs1      <= '0;
      fpu_fs2      <= '0;
      fpu_fs3      <= '0;
      fpu_rounding <= '0;
    end else begin
      fpu_active <= accept;
      if (accept) begin
        prio         <= ~win_id;
        id_q         <= win_id;
        fpu_op       <= win_id ? req1_op  : req0_op;
        fpu_fs1      <= win_id ? req1_fs1 : req0_fs1;
        fpu_fs2      <= win_id ? req1_fs2 : req0_fs2;
        fpu_fs3      <= win_id ? req1_fs3 : req0_fs3;
        fpu_rounding <= win_id ? req1_rm  : req0_rm;
      end else if ((state == RESP) && rsp_ready) begin
        fpu_op <= '0;
      end
    end
  end

  // Response side: registers only change on entry to RESP or on completion capture.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      if ((state != RESP) && (state_nxt == RESP)) begin
        rsp_id <= id_q;
      end
      if (cpl_take) begin
        rsp_data  <= fpu_result;
        rsp_flags <= fpu_sflag;
      end else if (to_fire) begin
        rsp_data  <= '0;
        rsp_flags <= 5'b10000;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb/tb_fpu_issue_arbiter.sv - directed table-driven bench for fpu_issue_arbiter
// Timeout checks follow FPU_ARB_TIMEOUT_EN (TIMEOUT_CYC=8 when built in).
module tb_fpu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_op, req1_op;
  logic [15:0] req0_fs1, req0_fs2, req0_fs3, req1_fs1, req1_fs2, req1_fs3;
  logic [2:0]  req0_rm, req1_rm;
  logic        fpu_active;
  logic [23:0] fpu_op;
  logic [15:0] fpu_fs1, fpu_fs2, fpu_fs3;
  logic [2:0]  fpu_rounding;
  logic        fpu_complete;
  logic [15:0] fpu_result;
  logic [4:0]  fpu_sflag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_timeout, busy;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;

  logic        auto_cpl, cpl_drv;
  logic [15:0] res_drv;
  logic [4:0]  flg_drv;

  // FPU model: either echoes fpu_active with fs1+1, or is driven pulse by pulse.
  assign fpu_complete = auto_cpl ? fpu_active : cpl_drv;
  assign fpu_result   = auto_cpl ? (fpu_fs1 + 16'h0001) : res_drv;
  assign fpu_sflag    = auto_cpl ? 5'b00001 : flg_drv;

  always #5 clk = ~clk;

  fpu_issue_arbiter #(.OP_W(24), .DATA_W(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_l(rst_l),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_fs1(req0_fs1), .req0_fs2(req0_fs2), .req0_fs3(req0_fs3), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_fs1(req1_fs1), .req1_fs2(req1_fs2), .req1_fs3(req1_fs3), .req1_rm(req1_rm),
    .fpu_active(fpu_active), .fpu_op(fpu_op), .fpu_fs1(fpu_fs1), .fpu_fs2(fpu_fs2),
    .fpu_fs3(fpu_fs3), .fpu_rounding(fpu_rounding), .fpu_complete(fpu_complete),
    .fpu_result(fpu_result), .fpu_sflag(fpu_sflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  typedef struct {
    logic        port;
    logic [23:0] op;
    logic [15:0] fs1, fs2, fs3;
    logic [2:0]  rm;
    int          k;
    logic [15:0] res;
    logic [4:0]  flg;
    logic [15:0] exp_data;
    logic [4:0]  exp_flags;
    int          exp_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    cpl_drv = 1'b0; auto_cpl = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic drive_req(input logic port, input logic [23:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c, input logic [2:0] rm);
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_fs1 = a; req1_fs2 = b; req1_fs3 = c; req1_rm = rm;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_fs1 = a; req0_fs2 = b; req0_fs3 = c; req0_rm = rm;
    end
  endtask

  // Called right after a falling edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int   n;
    logic got;
    drive_req(v.port, v.op, v.fs1, v.fs2, v.fs3, v.rm);
    #1;
    chk("vec_ready", v.port ? req1_ready : req0_ready, 1);
    chk("vec_idle_busy", busy, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("vec_active", fpu_active, 1);
    chk("vec_op", fpu_op, v.op);
    chk("vec_fs1", fpu_fs1, v.fs1);
    chk("vec_fs2", fpu_fs2, v.fs2);
    chk("vec_fs3", fpu_fs3, v.fs3);
    chk("vec_rm", fpu_rounding, v.rm);
    n = 1; got = 1'b0;
    cpl_drv = (v.k == 0);
    res_drv = (v.k == 0) ? v.res : 16'hDEAD;
    flg_drv = (v.k == 0) ? v.flg : 5'b11111;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      cpl_drv = (n == 1 + v.k);
      res_drv = cpl_drv ? v.res : 16'hDEAD;
      flg_drv = cpl_drv ? v.flg : 5'b11111;
      #1;
      if (n == 2) chk("vec_active_once", fpu_active, 0);
      if (rsp_valid) got = 1'b1;
    end
    cpl_drv = 1'b0;
    chk("vec_latency", n, v.exp_lat);
    chk("vec_rsp_id", rsp_id, v.port);
    chk("vec_rsp_data", rsp_data, v.exp_data);
    chk("vec_rsp_flags", rsp_flags, v.exp_flags);
    chk("vec_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("vec_back_idle", busy, 0);
    chk("vec_rsp_drop", rsp_valid, 0);
    chk("vec_op_clear", fpu_op, 0);
    chk("vec_fs1_keep", fpu_fs1, v.fs1);
  endtask

  vec_t vecs[5];
  int   gport[8], gcyc[8];
  logic rid[8];
  logic [15:0] rdat[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ngr, nrs, n, errs;
    logic p0, p1, got;

    vecs[0] = '{1'b0, 24'h000001, 16'h3C00, 16'h4000, 16'h0000, 3'd0, 2, 16'h4200, 5'b00000, 16'h4200, 5'b00000, 4};
    vecs[1] = '{1'b1, 24'h000002, 16'h4000, 16'h4200, 16'h0000, 3'd1, 0, 16'h4600, 5'b00000, 16'h4600, 5'b00000, 2};
    vecs[2] = '{1'b0, 24'h000004, 16'h3C00, 16'h0000, 16'h0000, 3'd0, 1, 16'h7C00, 5'b01000, 16'h7C00, 5'b01000, 3};
    vecs[3] = '{1'b1, 24'h000400, 16'hBC00, 16'h0000, 16'h0000, 3'd3, 3, 16'h7E00, 5'b10000, 16'h7E00, 5'b10000, 5};
    vecs[4] = '{1'b0, 24'h800000, 16'h3C00, 16'h3C00, 16'h3C00, 3'd4, 0, 16'h4000, 5'b00001, 16'h4000, 5'b00001, 2};

    req0_valid = 0; req1_valid = 0; rsp_ready = 0; auto_cpl = 0; cpl_drv = 0;
    res_drv = 0; flg_drv = 0;
    req0_op = 0; req0_fs1 = 0; req0_fs2 = 0; req0_fs3 = 0; req0_rm = 0;
    req1_op = 0; req1_fs1 = 0; req1_fs2 = 0; req1_fs3 = 0; req1_rm = 0;

    #1 rst_l = 1'b0;
    #1;
    chk("rst_active", fpu_active, 0);
    chk("rst_op", fpu_op, 0);
    chk("rst_fs1", fpu_fs1, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both ports hammering: strict alternation starting with port 0.
    do_reset();
    auto_cpl = 1'b1; rsp_ready = 1'b1;
    drive_req(1'b0, 24'h000001, 16'h0100, 16'h0, 16'h0, 3'd0);
    drive_req(1'b1, 24'h000002, 16'h0200, 16'h0, 16'h0, 3'd0);
    ngr = 0; nrs = 0; p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 8; i++) begin gport[i] = -1; gcyc[i] = -100; rid[i] = 1'bx; rdat[i] = 16'hxxxx; end
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("rr_r0_repeat", req0_ready & p0, 0);
      chk("rr_r1_repeat", req1_ready & p1, 0);
      chk("rr_both_ready", req0_ready & req1_ready, 0);
      p0 = req0_ready; p1 = req1_ready;
      if ((req0_ready || req1_ready) && ngr < 8) begin gport[ngr] = int'(req1_ready); gcyc[ngr] = c; ngr++; end
      if (rsp_valid && nrs < 8) begin
        rid[nrs] = rsp_id; rdat[nrs] = rsp_data; nrs++;
        chk("rr_flags", rsp_flags, 5'b00001);
      end
      @(negedge clk);
      if (ngr >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("rr_grant_count", ngr, 4);
    chk("rr_rsp_count", nrs, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_port", gport[i], i % 2);
      chk("rr_rsp_id", rid[i], i % 2);
      chk("rr_rsp_data", rdat[i], (i % 2) ? 16'h0201 : 16'h0101);
      if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 3);
    end

    // Backpressure with port 1 waiting behind a port 0 operation.
    do_reset();
    drive_req(1'b1, 24'h000010, 16'h4400, 16'h0000, 16'h0000, 3'd2);
    drive_req(1'b0, 24'h000008, 16'h3800, 16'h3800, 16'h0000, 3'd0);
    #1;
    chk("bp_r0_first", req0_ready, 1);
    chk("bp_r1_first", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 1; got = 1'b0;
    while (!got && n < 40) begin
      #1 chk("bp_r1_blocked", req1_ready, 0);
      @(negedge clk);
      n++;
      cpl_drv = (n == 2);
      res_drv = cpl_drv ? 16'h5500 : 16'hDEAD;
      flg_drv = cpl_drv ? 5'b00010 : 5'b11111;
      #1;
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_latency", n, 3);
    for (int c = 0; c < 10; c++) begin
      cpl_drv = (c == 4); res_drv = 16'h1234; flg_drv = 5'b11111;
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'h5500);
      chk("bp_flags", rsp_flags, 5'b00010);
      chk("bp_id", rsp_id, 0);
      chk("bp_r1_held", req1_ready, 0);
      @(negedge clk);
    end
    cpl_drv = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_r1_grant", req1_ready, 1);
    chk("bp_idle", busy, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("bp_p1_active", fpu_active, 1);
    chk("bp_p1_fs1", fpu_fs1, 16'h4400);
    chk("bp_p1_rm", fpu_rounding, 3'd2);
    chk("bp_p1_op", fpu_op, 24'h000010);

    // Asynchronous reset in the middle of WAIT, then a stale completion.
    @(negedge clk);
    @(negedge clk);
    #1 chk("ar_in_wait", busy, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("ar_active", fpu_active, 0);
    chk("ar_op", fpu_op, 0);
    chk("ar_fs1", fpu_fs1, 0);
    chk("ar_rm", fpu_rounding, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rsp_data", rsp_data, 0);
    chk("ar_rsp_flags", rsp_flags, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpl_drv = 1'b1; res_drv = 16'hBEEF; flg_drv = 5'b00100;
    @(negedge clk);
    cpl_drv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("ar_stale_valid", rsp_valid, 0);
      chk("ar_stale_busy", busy, 0);
      chk("ar_stale_data", rsp_data, 0);
      @(negedge clk);
    end

    // FPU that never answers.
    drive_req(1'b0, 24'h000020, 16'h1111, 16'h2222, 16'h3333, 3'd0);
    #1 chk("to_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 1;
`ifdef FPU_ARB_TIMEOUT_EN
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      #1;
      if (rsp_valid) got = 1'b1;
    end
    chk("to_latency", n, 10);
    chk("to_flag", rsp_timeout, 1);
    chk("to_flags", rsp_flags, 5'b10000);
    chk("to_data", rsp_data, 0);
    chk("to_id", rsp_id, 0);
    cpl_drv = 1'b1; res_drv = 16'h7777; flg_drv = 5'b00001;
    @(negedge clk);
    cpl_drv = 1'b0;
    #1;
    chk("to_late_data", rsp_data, 0);
    chk("to_late_flag", rsp_timeout, 1);
    chk("to_late_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("to_idle", busy, 0);
    chk("to_rsp_drop", rsp_valid, 0);
`else
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (!busy || rsp_valid) errs++;
    end
    chk("nto_busy_stuck", errs, 0);
    chk("nto_busy", busy, 1);
    chk("nto_flag", rsp_timeout, 0);
    chk("nto_op_held", fpu_op, 24'h000020);
    chk("nto_fs3_held", fpu_fs3, 16'h3333);
    do_reset();
    #1 chk("nto_reset_idle", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_arbiter.md
# fpu_issue_arbiter

Shares the single half-precision FPU execution unit between two requesters: port 0 is the decoded-instruction path and port 1 is the debug/UART injection path. The block arbitrates round-robin and issues one operation at a time, driving the FPU operand/op/rounding bus with a one-cycle `fpu_active` strobe. It waits for `fpu_complete`, then returns the result and sticky flags to the winning requester on a shared response channel. It sits between the decode stage and the FPU execution unit, and owns `fpu_active` for that unit.

## Interface
Parameters:
- `OP_W`, 24, width of the one-hot FPU operation vector (`sfpu_op`)
- `DATA_W`, 16, operand/result width (half precision)
- `TIMEOUT_CYC`, 64, WAIT-state cycles before abandon (used only with `FPU_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_l`  in  1  asynchronous active-low reset
- `reqN_valid`  in  1  (N=0,1) request pending
- `reqN_ready`  out  1  request accepted this cycle
- `reqN_op`  in  OP_W  operation vector
- `reqN_fs1/fs2/fs3`  in  DATA_W  operands
- `reqN_rm`  in  3  rounding mode
- `fpu_active`  out  1  issue strobe to FPU
- `fpu_op`  out  OP_W  registered op
- `fpu_fs1/fs2/fs3`  out  DATA_W  registered operands
- `fpu_rounding`  out  3  registered rounding mode
- `fpu_complete`  in  1  FPU done pulse
- `fpu_result`  in  DATA_W  FPU result, valid with `fpu_complete`
- `fpu_sflag`  in  5  exception flags (NV,DZ,OF,UF,NX), valid with `fpu_complete`
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_id`  out  1  requester owning the response
- `rsp_data`  out  DATA_W  result
- `rsp_flags`  out  5  flags
- `rsp_timeout`  out  1  response is a timeout abort
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset: IDLE, round-robin pointer favours port 0, all outputs and registers 0.
- IDLE: grant is combinational. A lone valid port wins. With both valid, the winner is the port not granted last. `reqN_ready` = (state==IDLE) & grantN. On acceptance: capture op/operands/rm/id, flip the pointer to the winner, go to ISSUE.
- ISSUE: `fpu_active`=1 for exactly this cycle. If `fpu_complete` is high in this cycle (single-cycle op), go to RESP; otherwise go to WAIT.
- WAIT: `fpu_active`=0. `fpu_op`/operands/rounding hold their registered values. On `fpu_complete`: capture `fpu_result` and `fpu_sflag`, go to RESP.
- RESP: `rsp_valid`=1. `rsp_*` hold stable until `rsp_valid & rsp_ready`, then go to IDLE. No new grant occurs in the RESP cycle.
- `fpu_complete` in IDLE or RESP is ignored and does not alter state or response registers.
- `reqN_ready` is never high outside IDLE. A requester may drop valid before grant without effect.
- `fpu_op` is cleared to 0 on return to IDLE. Operand buses keep their last values.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0. An FPU completion that arrives after reset release is ignored.

## Timing
- Request accepted at cycle T → `fpu_active` at T+1 → `fpu_complete` at T+1+k (k≥0) → `rsp_valid` at T+2+k.
- With `rsp_ready` held high: IDLE at T+3+k, and the next grant at T+3+k at the earliest.
- Peak throughput is one operation per 3 cycles for single-cycle ops.
- All outputs are registered except `reqN_ready` and `busy`.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC` without completion, go to RESP with `rsp_timeout`=1, `rsp_data`=0, `rsp_flags`=5'b10000 (NV).
  - A late `fpu_complete` after the abort is ignored.
- Undefined: no counter. WAIT persists until `fpu_complete`, and `rsp_timeout` is tied 0.

## Test plan
- Single port-0 request: op=fadd, fs1=16'h3C00, fs2=16'h4000, FPU model returns 16'h4200 after k=2. Expect: `fpu_active` one cycle at T+1; `rsp_valid` at T+4, `rsp_id`=0, `rsp_data`=16'h4200; IDLE the cycle after `rsp_ready`.
- Both ports valid continuously for 4 operations. Expect grants in order 0,1,0,1; `reqN_ready` never high in two consecutive cycles for the same port.
- Single-cycle op: `fpu_complete` coincident with `fpu_active` (k=0). Expect: no WAIT state; `rsp_valid` at T+2.
- Backpressure: hold `rsp_ready`=0 for 10 cycles while port 1 is valid. Expect: `rsp_*` stable, `req1_ready`=0 throughout; grant to port 1 the cycle after the handshake.
- Async reset asserted in WAIT, then `fpu_complete` 2 cycles after release. Expect: all outputs 0 immediately, state IDLE, no `rsp_valid`.
- With `FPU_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=8, FPU never completes. Expect: `rsp_valid` with `rsp_timeout`=1 and `rsp_flags`=5'b10000 at T+10. Without the macro, expect `busy` to remain 1 indefinitely.
